// File: rtl/step_gen_multi.sv
// rtl/step_gen_multi.sv - multi-channel step/dir pulse generator with per-channel period and distance
// Optional endstop inputs are compiled in with STEP_LIMIT_EN.
module step_gen_multi #(
  parameter int NCH      = 3,
  parameter int DIS_W    = 11,
  parameter int V_W      = 26,
  parameter int MSTEP_SH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef STEP_LIMIT_EN
  input  logic [NCH-1:0]       limit,
`endif
  input  logic                 start,
  input  logic                 abort,
  input  logic [NCH*DIS_W-1:0] dis,
  input  logic [NCH*V_W-1:0]   per,
  input  logic [NCH-1:0]       dir_in,
  output logic [NCH-1:0]       step,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       active,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int RW = DIS_W + MSTEP_SH;
  localparam logic [V_W-1:0] V_ONE = 1;
  localparam logic [RW-1:0]  R_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state;
  logic [V_W-1:0] per_q   [NCH];
  logic [V_W-1:0] cnt     [NCH];
  logic [RW-1:0]  rem     [NCH];
  logic [V_W-1:0] cnt_nxt [NCH];
  logic [RW-1:0]  rem_nxt [NCH];
  logic [NCH-1:0] fire;
  logic           all_zero;

  // Per-channel period tick and edge bookkeeping for one RUN cycle.
  always_comb begin
    all_zero = 1'b1;
    fire     = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = cnt[i] + V_ONE;
      rem_nxt[i] = rem[i];
      if (rem[i] != '0) all_zero = 1'b0;
      if (cnt[i] >= per_q[i]) begin
        cnt_nxt[i] = '0;
        if (rem[i] != '0) begin
          fire[i]    = 1'b1;
          rem_nxt[i] = rem[i] - R_ONE;
        end
      end
`ifdef STEP_LIMIT_EN
      // An endstop retires the channel without emitting the pending edge.
      if (limit[i]) begin
        fire[i]    = 1'b0;
        rem_nxt[i] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      dir     <= '0;
      active  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        per_q[i] <= '0;
        cnt[i]   <= '0;
        rem[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          active <= '0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
            active  <= '0;
            for (int i = 0; i < NCH; i++) rem[i] <= '0;
          end else begin
            state   <= RUN;
            dir     <= dir_in;
            aborted <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
              per_q[i]  <= per[i*V_W +: V_W];
              cnt[i]    <= '0;
              rem[i]    <= {dis[i*DIS_W +: DIS_W], {MSTEP_SH{1'b0}}};
              active[i] <= (dis[i*DIS_W +: DIS_W] != '0);
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
            active  <= '0;
            for (int i = 0; i < NCH; i++) rem[i] <= '0;
          end else if (all_zero) begin
            state  <= DONE;
            done   <= 1'b1;
            active <= '0;
          end else begin
            step <= step ^ fire;
            for (int i = 0; i < NCH; i++) begin
              cnt[i]    <= cnt_nxt[i];
              rem[i]    <= rem_nxt[i];
              active[i] <= (rem_nxt[i] != '0);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          active <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_gen_multi.sv
// tb/tb_step_gen_multi.sv - directed scoreboard bench for step_gen_multi
module tb_step_gen_multi;
  localparam int NCH = 3, DIS_W = 11, V_W = 26, MSTEP_SH = 4;

  logic                 clk = 1'b0;
  logic                 rst, start, abort;
  logic [NCH*DIS_W-1:0] dis;
  logic [NCH*V_W-1:0]   per;
  logic [NCH-1:0]       dir_in, step, dir, active;
  logic                 busy, done, aborted;
`ifdef STEP_LIMIT_EN
  logic [NCH-1:0]       limit;
`endif

  step_gen_multi #(.NCH(NCH), .DIS_W(DIS_W), .V_W(V_W), .MSTEP_SH(MSTEP_SH)) dut (
    .clk(clk), .rst(rst),
`ifdef STEP_LIMIT_EN
    .limit(limit),
`endif
    .start(start), .abort(abort), .dis(dis), .per(per), .dir_in(dir_in),
    .step(step), .dir(dir), .active(active), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [NCH-1:0][15:0] tog;
    logic [NCH-1:0][15:0] gap;
    logic                 ab;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int tog[NCH], terr[NCH];
  int t0 = 0;
  logic [NCH-1:0] prev;
  logic prev_busy = 1'b0, done_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Toggle monitor: counts edges, checks their timing, and scores each done pulse.
  always @(negedge clk) begin
    if (done_last) check("done_width", {busy, done}, 0);
    done_last = 1'b0;
    if (busy !== 1'b1) begin
      for (int c = 0; c < NCH; c++) begin tog[c] = 0; terr[c] = 0; end
      prev = step;
      prev_busy = 1'b0;
    end else begin
      if (!prev_busy) t0 = cyc;
      prev_busy = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (step[c] !== prev[c]) begin
          tog[c]++;
          if (q.size() > 0 && cyc != t0 + tog[c] * int'(q[0].gap[c]) + 1) terr[c]++;
        end
      end
      prev = step;
      if (done === 1'b1) begin
        exp_t e;
        done_last = 1'b1;
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          for (int c = 0; c < NCH; c++) begin
            check($sformatf("toggles_ch%0d", c), tog[c], e.tog[c]);
            check($sformatf("timing_ch%0d", c), terr[c], 0);
          end
          check("aborted", aborted, e.ab);
          check("active_in_done", active, 0);
        end
      end
    end
  end

  task automatic drive(input int d0, d1, d2, p0, p1, p2, input logic [NCH-1:0] dv);
    dis = {DIS_W'(d2), DIS_W'(d1), DIS_W'(d0)};
    per = {V_W'(p2), V_W'(p1), V_W'(p0)};
    dir_in = dv;
  endtask

  task automatic push_exp(input int t0_, t1_, t2_, g0, g1, g2, input logic ab);
    exp_t e;
    e.tog = {16'(t2_), 16'(t1_), 16'(t0_)};
    e.gap = {16'(g2), 16'(g1), 16'(g0)};
    e.ab = ab;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_step"}, step, 0);
    check({tag, "_dir"}, dir, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_flags"}, {busy, done, aborted}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef STEP_LIMIT_EN
    limit = '0;
`endif
    drive(0, 0, 0, 0, 0, 0, 3'b000);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three channels, mixed periods, one idle channel; dir_in moves mid-run.
    drive(2, 1, 0, 0, 3, 5, 3'b101);
    push_exp(32, 16, 0, 1, 4, 6, 1'b0);
    pulse_start();
    repeat (10) @(negedge clk);
    check("A_active", active, 3'b011);
    dir_in = 3'b010;
    check("A_dir_run", dir, 3'b101);
    wait_done(200, "A_done");
    check("A_dir_after", dir, 3'b101);

    // Abort after 50 RUN cycles: edges at 10,20,30,40,50.
    drive(1, 0, 0, 9, 0, 0, 3'b001);
    push_exp(5, 0, 0, 10, 1, 1, 1'b1);
    pulse_start();
    check("B_dir_load", dir, 3'b101);
    repeat (51) @(negedge clk);
    check("B_dir_run", dir, 3'b001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("B_done_next", done, 1);
    check("B_aborted", aborted, 1);
    @(negedge clk);
    check("B_done_gone", done, 0);
    repeat (2) @(negedge clk);
    check("B_abort_idle", {busy, aborted}, 2'b01);

    // Start while busy is ignored; aborted cleared by the next LOAD.
    drive(1, 0, 0, 1, 0, 0, 3'b000);
    push_exp(16, 0, 0, 2, 1, 1, 1'b0);
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(100, "C_done");
    repeat (5) @(negedge clk);
    check("C_no_restart", busy, 0);
    check("C_sb_empty", q.size(), 0);

    drive(0, 0, 0, 0, 0, 0, 3'b000);
    push_exp(0, 0, 0, 1, 1, 1, 1'b0);
    pulse_start();
    wait_done(3, "C_zero_done");

    // Reset in the 10th RUN cycle, then a full move.
    drive(2, 0, 0, 0, 0, 0, 3'b110);
    pulse_start();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("D_midreset");
    rst = 1'b0;
    @(negedge clk);
    drive(1, 1, 1, 2, 0, 1, 3'b011);
    push_exp(16, 16, 16, 3, 1, 2, 1'b0);
    pulse_start();
    wait_done(100, "D_done");
    check("D_dir", dir, 3'b011);

`ifdef STEP_LIMIT_EN
    begin
      int k = 0;
      drive(1, 1, 0, 1, 2, 0, 3'b000);
      push_exp(16, 3, 0, 2, 3, 1, 1'b0);
      pulse_start();
      while (tog[1] < 3 && k < 50) begin @(negedge clk); k++; end
      check("F_reach3", tog[1], 3);
      limit = 3'b010;
      @(negedge clk);
      limit = '0;
      check("F_ch1_inactive", active[1], 0);
      wait_done(100, "F_done");
    end
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
